// File: rtl/bus_rr_arbiter.sv
// Broadcast bus controller: arbitrates N source FIFOs (fixed-priority or
// round-robin) and moves one packet at a time to a unicast or broadcast target.
module bus_rr_arbiter #(
  parameter int unsigned       DRVRS   = 4,
  parameter int unsigned       PCKG_SZ = 16,
  parameter int unsigned       ID_W    = 8,
  parameter logic [ID_W-1:0]   BCAST   = 8'hFF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DRVRS-1:0]                  pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]     D_pop,
  output logic [DRVRS-1:0]                  pop,
  input  logic [DRVRS-1:0]                  full,
  output logic [DRVRS-1:0]                  push,
  output logic [DRVRS-1:0][PCKG_SZ-1:0]     D_push,
  input  logic                              mode,
  output logic [15:0]                       drop_cnt
);

  localparam int unsigned IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SEND} state_e;

  state_e                         state_q, state_d;
  logic [IW-1:0]                  grant_q, grant_d;
  logic [IW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [PCKG_SZ-1:0]             pkt_q, pkt_d;
  logic                           done_q, done_d;
  logic [DRVRS-1:0]               pop_q, pop_d;
  logic [DRVRS-1:0]               push_q, push_d;
  logic [DRVRS-1:0][PCKG_SZ-1:0]  d_push_q, d_push_d;
  logic [15:0]                    drop_cnt_q, drop_cnt_d;

  logic [IW-1:0]                  idx;
  logic [IW-1:0]                  sel;
  logic                           found;
  logic [PCKG_SZ-1:0]             cand;
  logic [ID_W-1:0]                dst;
  logic                           is_bcast;
  logic                           is_uni;
  logic                           deliver;
  logic [DRVRS-1:0]               tgt;

  // Grant selection: mode 0 scans from index 0, mode 1 scans from rr_ptr+1 cyclically.
  always_comb begin
    idx   = '0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < DRVRS; k++) begin
      idx = mode ? IW'((32'(rr_ptr_q) + k + 1) % DRVRS) : IW'(k);
      if (!found && pndng[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // The delivery decision is made on the GRANT edge straight from D_pop, so the
  // push lands one cycle after pop; pkt_q only serves the backpressure retries.
  always_comb begin
    cand     = (state_q == GRANT) ? D_pop[grant_q] : pkt_q;
    dst      = cand[PCKG_SZ-1 -: ID_W];
    is_bcast = (dst == BCAST);
    is_uni   = !is_bcast && (32'(dst) < DRVRS) && (32'(dst) != 32'(grant_q));
    tgt      = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      tgt[i] = is_bcast ? (i != 32'(grant_q)) : (is_uni && (32'(dst) == i));
    end
    deliver  = (is_bcast || is_uni) && ((full & tgt) == '0);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_d      = pkt_q;
    done_d     = done_q;
    pop_d      = '0;
    push_d     = '0;
    d_push_d   = d_push_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = sel;
          pop_d[sel] = 1'b1;
          state_d    = GRANT;
          if (mode) rr_ptr_d = sel;
        end
      end
      GRANT: begin
        pkt_d   = cand;
        state_d = SEND;
        done_d  = 1'b0;
        if (!(is_bcast || is_uni)) begin
          done_d = 1'b1;
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end else if (deliver) begin
          push_d = tgt;
          done_d = 1'b1;
        end
      end
      SEND: begin
        if (done_q) begin
          state_d = IDLE;
        end else if (deliver) begin
          push_d  = tgt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (push_d[i]) d_push_d[i] = cand;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IW'(DRVRS - 1);
      pkt_q      <= '0;
      done_q     <= 1'b0;
      pop_q      <= '0;
      push_q     <= '0;
      d_push_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      pkt_q      <= pkt_d;
      done_q     <= done_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      d_push_q   <= d_push_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = d_push_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: modelled source FIFOs feed the DUT,
// expected grants/pushes are queued at load time and matched on output.
module tb_bus_rr_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          pndng;
  logic [N-1:0][W-1:0]   D_pop;
  logic [N-1:0]          pop;
  logic [N-1:0]          full;
  logic [N-1:0]          push;
  logic [N-1:0][W-1:0]   D_push;
  logic                  mode;
  logic [15:0]           drop_cnt;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } push_t;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [W-1:0]  fifo[N][$];
  logic [N-1:0]  exp_pop[$];
  push_t         exp_push[$];
  int unsigned   exp_drop = 0;
  logic [N-1:0]  pop_seen = '0;
  int unsigned   cyc = 0;
  int unsigned   last_push_cyc = 0;
  logic          gap_en = 1'b0;

  bus_rr_arbiter #(.DRVRS(N), .PCKG_SZ(W), .ID_W(8), .BCAST(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .full(full), .push(push), .D_push(D_push), .mode(mode), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic load(input int unsigned s, input logic [W-1:0] pkt);
    fifo[s].push_back(pkt);
  endtask

  task automatic expect_pkt(input int unsigned s, input logic [W-1:0] pkt);
    logic [7:0] d;
    push_t e;
    d = pkt[W-1 -: 8];
    exp_pop.push_back(N'(1) << s);
    if (d == 8'hFF) begin
      e.mask = ~(N'(1) << s);
      e.data = pkt;
      exp_push.push_back(e);
    end else if (32'(d) < N && 32'(d) != s) begin
      e.mask = N'(1) << d;
      e.data = pkt;
      exp_push.push_back(e);
    end else if (exp_drop < 65535) begin
      exp_drop++;
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  // Source FIFO model: pops on the edge that closes a pop cycle, head updates after it.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (pop_seen[i] && fifo[i].size() != 0) fifo[i].delete(0);
      pndng[i] = (fifo[i].size() != 0);
      D_pop[i] = (fifo[i].size() != 0) ? fifo[i][0] : '0;
    end
  end

  always @(negedge clk) begin
    push_t e;
    pop_seen = pop;
    if (pop != '0) begin
      if (exp_pop.size() == 0) check("pop_unexpected", 32'(pop), 32'(0));
      else check("pop_grant", 32'(pop), 32'(exp_pop.pop_front()));
    end
    if (push != '0) begin
      if (gap_en) begin
        if (last_push_cyc != 0) check("push_gap", cyc - last_push_cyc, 32'd3);
        last_push_cyc = cyc;
      end
      if (exp_push.size() == 0) begin
        check("push_unexpected", 32'(push), 32'(0));
      end else begin
        e = exp_push.pop_front();
        check("push_mask", 32'(push), 32'(e.mask));
        for (int i = 0; i < N; i++)
          if (e.mask[i]) check("d_push_lane", 32'(D_push[i]), 32'(e.data));
      end
    end
  end

  initial begin
    logic [W-1:0] p;
    reset = 1'b0;
    full  = '0;
    mode  = 1'b0;
    #1;
    check("rst_pop", 32'(pop), 32'(0));
    check("rst_push", 32'(push), 32'(0));
    check("rst_drop", 32'(drop_cnt), 32'(0));
    for (int i = 0; i < N; i++) check("rst_d_push", 32'(D_push[i]), 32'(0));
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(1);

    // Unicast with exact latency
    load(0, 16'h02AB);
    expect_pkt(0, 16'h02AB);
    wait_cyc(1);
    check("uni_pop_early", 32'(pop), 32'(0));
    wait_cyc(1);
    check("uni_pop", 32'(pop), 32'h1);
    check("uni_push_early", 32'(push), 32'(0));
    wait_cyc(1);
    check("uni_push", 32'(push), 32'h4);
    check("uni_data", 32'(D_push[2]), 32'h02AB);
    check("uni_pop_once", 32'(pop), 32'(0));
    wait_cyc(4);

    // Round-robin fairness: two packets per source
    mode = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++) begin
        p = {8'((s + 1) % N), 8'((s << 4) | k)};
        load(s, p);
        expect_pkt(s, p);
      end
    gap_en = 1'b1;
    last_push_cyc = 0;
    wait_cyc(30);

    // Fixed priority: source 0 wins while it has data
    mode = 1'b0;
    last_push_cyc = 0;
    for (int k = 0; k < 3; k++) begin
      p = {8'd1, 8'(8'h80 | k)};
      load(0, p);
    end
    for (int s = 1; s < N; s++) load(s, {8'((s + 1) % N), 8'(8'h90 | s)});
    for (int k = 0; k < 3; k++) expect_pkt(0, {8'd1, 8'(8'h80 | k)});
    for (int s = 1; s < N; s++) expect_pkt(s, {8'((s + 1) % N), 8'(8'h90 | s)});
    wait_cyc(25);
    gap_en = 1'b0;

    // Broadcast held off by full[3]
    full[3] = 1'b1;
    load(1, 16'hFF5C);
    expect_pkt(1, 16'hFF5C);
    for (int c = 0; c < 6; c++) begin
      wait_cyc(1);
      check("bcast_hold", 32'(push), 32'(0));
    end
    full[3] = 1'b0;
    wait_cyc(1);
    check("bcast_mask", 32'(push), 32'hD);
    wait_cyc(4);

    // Drops: invalid ID and self-addressed
    load(2, 16'h0711);
    load(2, 16'h0299);
    expect_pkt(2, 16'h0711);
    expect_pkt(2, 16'h0299);
    wait_cyc(10);
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    force dut.drop_cnt_q = 16'hFFFF;
    wait_cyc(1);
    release dut.drop_cnt_q;
    exp_drop = 65535;
    wait_cyc(1);
    check("drop_forced", 32'(drop_cnt), 32'hFFFF);
    load(2, 16'h0711);
    expect_pkt(2, 16'h0711);
    wait_cyc(6);
    check("drop_sat", 32'(drop_cnt), 32'(exp_drop));

    // Move rr_ptr off its reset value so a reset is observable
    mode = 1'b1;
    load(1, 16'h0260);
    expect_pkt(1, 16'h0260);
    wait_cyc(6);

    // Reset while waiting on full[0]: packet from source 3 is lost
    mode = 1'b0;
    full[0] = 1'b1;
    load(3, 16'h0033);
    exp_pop.push_back(4'b1000);
    wait_cyc(4);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_push", 32'(push), 32'(0));
    check("mid_rst_pop", 32'(pop), 32'(0));
    check("mid_rst_drop", 32'(drop_cnt), 32'(0));
    for (int i = 0; i < N; i++) check("mid_rst_d_push", 32'(D_push[i]), 32'(0));
    exp_drop = 0;
    wait_cyc(2);
    reset = 1'b1;
    full = '0;
    wait_cyc(6);

    mode = 1'b1;
    load(3, 16'h0044);
    load(1, 16'h0055);
    expect_pkt(1, 16'h0055);
    expect_pkt(3, 16'h0044);
    wait_cyc(12);

    check("sb_push_drained", exp_push.size(), 32'(0));
    check("sb_pop_drained", exp_pop.size(), 32'(0));
    check("final_drop", 32'(drop_cnt), 32'(exp_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
